// File: rtl/memblock_mp.sv
// Byte-writable word array with NRD async read ports and a background clear sequencer.
// Latency: reads combinational, writes land at the clock edge, a clear takes DEPTH cycles.
// Backpressure: none; writes while busy are discarded and flagged on wr_drop one cycle later.
module memblock_mp #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int NB   = WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we0,
    input  logic [AW-1:0]        wr_addr0,
    input  logic [WIDTH-1:0]     wr_din0,
    input  logic [NB-1:0]        wr_be0,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_dout,
    input  logic                 clr_req,
    output logic                 busy,
    output logic                 wr_drop
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic          wr_drop_q, wr_drop_d;
    logic          wr_ok;

    assign busy    = (state_q == CLEAR);
    assign wr_drop = wr_drop_q;
    assign wr_ok   = we0 && !busy && ({1'b0, wr_addr0} < DEPTH_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        wr_drop_d = we0 && busy;
        case (state_q)
            IDLE: begin
                // A coincident write still lands this edge; zeroing starts next edge.
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            CLEAR: begin
                if (clr_ptr_q == LAST_PTR) begin
                    state_d   = IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Array has no reset; rst only gates updates so a held reset blocks all writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (busy) begin
                mem[clr_ptr_q] <= '0;
            end else if (wr_ok) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_be0[b]) mem[wr_addr0][8*b +: 8] <= wr_din0[8*b +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rd_addr[p*AW +: AW];
        assign rd_dout[p*WIDTH +: WIDTH] =
            (!busy && ({1'b0, ra} < DEPTH_W)) ? mem[ra] : '0;
    end

endmodule

// File: tb/tb_memblock_mp.sv
// Directed bench for memblock_mp: default 32-deep instance plus a 20-deep instance.
module tb_memblock_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 32-deep instance
    logic        rst = 1'b1, we0 = 1'b0, clr_req = 1'b0;
    logic [4:0]  wr_addr0 = '0;
    logic [31:0] wr_din0 = '0;
    logic [3:0]  wr_be0 = '0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_dout;
    logic        busy, wr_drop;

    // 20-deep instance
    logic        rst2 = 1'b1, we2 = 1'b0, clr2 = 1'b0;
    logic [4:0]  wa2 = '0;
    logic [31:0] wd2 = '0;
    logic [3:0]  be2 = '0;
    logic [9:0]  ra2 = '0;
    logic [63:0] rd2;
    logic        busy2, drop2;

    memblock_mp u_dut (
        .clk(clk), .rst(rst), .we0(we0), .wr_addr0(wr_addr0), .wr_din0(wr_din0),
        .wr_be0(wr_be0), .rd_addr(rd_addr), .rd_dout(rd_dout), .clr_req(clr_req),
        .busy(busy), .wr_drop(wr_drop)
    );

    memblock_mp #(.WIDTH(32), .DEPTH(20), .NRD(2)) u_dut20 (
        .clk(clk), .rst(rst2), .we0(we2), .wr_addr0(wa2), .wr_din0(wd2),
        .wr_be0(be2), .rd_addr(ra2), .rd_dout(rd2), .clr_req(clr2),
        .busy(busy2), .wr_drop(drop2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  n;
    bit  bad_rd, bad_drop;

    initial begin
        // Async reset entry with no clock edge involved
        #1 rst = 1'b0; rst2 = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_drop", 64'(wr_drop), 64'd0);
        chk("rst_rd_zero", rd_dout, 64'd0);
        tick(); tick();

        // Release: busy exactly 32 cycles, reads zero, no drops
        rst = 1'b1;
        rd_addr = {5'd9, 5'd0};
        n = 0; bad_rd = 0; bad_drop = 0;
        while (busy && n < 200) begin
            if (rd_dout != 64'd0) bad_rd = 1;
            if (wr_drop) bad_drop = 1;
            tick(); n++;
        end
        chk("init_clear_len", 64'(n), 64'd32);
        chk("init_rd_zero", 64'(bad_rd), 64'd0);
        chk("init_no_drop", 64'(bad_drop), 64'd0);

        // Full-word write then byte-0 merge
        we0 = 1'b1; wr_addr0 = 5'd5; wr_din0 = 32'hDEADBEEF; wr_be0 = 4'b1111;
        tick();
        wr_din0 = 32'h000000AA; wr_be0 = 4'b0001;
        tick();
        we0 = 1'b0; rd_addr = {5'd5, 5'd5};
        #1;
        chk("be_merge_p0", 64'(rd_dout[31:0]), 64'hDEADBEAA);
        chk("be_merge_p1", 64'(rd_dout[63:32]), 64'hDEADBEAA);

        // Read-during-write: old before edge, new after
        we0 = 1'b1; wr_addr0 = 5'd3; wr_din0 = 32'hCAFEF00D; wr_be0 = 4'b1111;
        rd_addr = {5'd3, 5'd5};
        #1;
        chk("rdw_old", 64'(rd_dout[63:32]), 64'h0);
        tick();
        we0 = 1'b0;
        #1;
        chk("rdw_new", 64'(rd_dout[63:32]), 64'hCAFEF00D);
        chk("top_word", 64'(rd_dout[31:0]), 64'hDEADBEAA);

        // clr_req with coincident write to addr 7
        we0 = 1'b1; wr_addr0 = 5'd7; wr_din0 = 32'h1234; wr_be0 = 4'b1111; clr_req = 1'b1;
        #1;
        chk("clr_busy_pre", 64'(busy), 64'd0);
        tick();
        we0 = 1'b0; clr_req = 1'b0; rd_addr = {5'd7, 5'd5};
        #1;
        chk("clr_busy_post", 64'(busy), 64'd1);
        chk("clr_rd_masked", rd_dout, 64'd0);
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        chk("clr_len", 64'(n), 64'd32);
        #1;
        chk("clr_addr7_zero", 64'(rd_dout[63:32]), 64'h0);
        chk("clr_addr5_zero", 64'(rd_dout[31:0]), 64'h0);

        // Write + clr_req during CLEAR: dropped, single pulse, no extension
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        repeat (5) begin tick(); n++; end
        we0 = 1'b1; clr_req = 1'b1; wr_addr0 = 5'd2; wr_din0 = 32'hFFFFFFFF;
        #1;
        chk("drop_not_yet", 64'(wr_drop), 64'd0);
        tick(); n++;
        we0 = 1'b0; clr_req = 1'b0;
        #1;
        chk("drop_pulse", 64'(wr_drop), 64'd1);
        tick(); n++;
        chk("drop_one_cycle", 64'(wr_drop), 64'd0);
        while (busy && n < 200) begin tick(); n++; end
        chk("drop_clr_len", 64'(n), 64'd32);

        // 20-deep: reset at clr_ptr=10 restarts the clear
        rst2 = 1'b1;
        repeat (10) tick();
        rst2 = 1'b0;
        we2 = 1'b1; wa2 = 5'd4; wd2 = 32'h55555555; be2 = 4'b1111;
        #1;
        chk("d20_rst_busy", 64'(busy2), 64'd1);
        tick(); tick();
        rst2 = 1'b1; we2 = 1'b0;
        n = 0;
        while (busy2 && n < 200) begin tick(); n++; end
        chk("d20_clr_len", 64'(n), 64'd20);
        ra2 = {5'd4, 5'd25};
        #1;
        chk("d20_oob_rd", 64'(rd2[31:0]), 64'h0);
        chk("d20_no_rst_write", 64'(rd2[63:32]), 64'h0);

        // Last valid word and out-of-range write (ignored, not a drop)
        we2 = 1'b1; wa2 = 5'd19; wd2 = 32'hA5A5A5A5;
        tick();
        wa2 = 5'd25; wd2 = 32'h77777777;
        tick();
        we2 = 1'b0; ra2 = {5'd19, 5'd25};
        #1;
        chk("d20_oob_no_drop", 64'(drop2), 64'd0);
        chk("d20_last_word", 64'(rd2[63:32]), 64'hA5A5A5A5);
        chk("d20_oob_after_wr", 64'(rd2[31:0]), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
